rtc_timebase_ctrl: RTL and testbench

- Controller that sequences the RTC prescaler. It owns the programmable divide ratio, run/pause state and prescaler count, and emits a one-cycle tick strobe every DIV cycles.
- Tick drives a built-in hh:mm:ss time-of-day counter with a synchronous time-load path.
- Sits between the AXI register slave (config/run/load) and the display/washer logic (tick + time outputs).
- Replaces free-running toggle division with enable-based timing in the single i_clk domain.

---
 rtl/rtc_pkg.sv | 27 ++
 rtl/rtc_tod_counter.sv | 65 ++++++
 rtl/rtc_timebase_ctrl.sv | 147 ++++++++++++++
 tb/tb_rtc_timebase_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared encodings, field widths and range limits for the RTC timebase.
package rtc_pkg;

  localparam int HH_W    = 5;
  localparam int MS_W    = 6;
  localparam int DIV_MIN = 2;

  localparam logic [HH_W-1:0] HH_MAX = 5'd23;
  localparam logic [MS_W-1:0] MM_MAX = 6'd59;
  localparam logic [MS_W-1:0] SS_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } rtc_state_e;

  function automatic logic [HH_W-1:0] clamp_hh(input logic [HH_W-1:0] v);
    return (v > HH_MAX) ? HH_MAX : v;
  endfunction

  function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v,
                                               input logic [MS_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/rtc_tod_counter.sv
// hh:mm:ss time-of-day counter; advances on tick, synchronous load with
// range clamping. A load in the same cycle as a tick takes priority.
module rtc_tod_counter
  import rtc_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_tick,
  input  logic            i_load,
  input  logic [HH_W-1:0] i_load_hh,
  input  logic [MS_W-1:0] i_load_mm,
  input  logic [MS_W-1:0] i_load_ss,
  output logic [HH_W-1:0] o_hh,
  output logic [MS_W-1:0] o_mm,
  output logic [MS_W-1:0] o_ss
);

  logic [HH_W-1:0] r_hh;
  logic [MS_W-1:0] r_mm;
  logic [MS_W-1:0] r_ss;

  logic [HH_W-1:0] w_hh_nxt;
  logic [MS_W-1:0] w_mm_nxt;
  logic [MS_W-1:0] w_ss_nxt;

  always_comb begin
    w_hh_nxt = r_hh;
    w_mm_nxt = r_mm;
    w_ss_nxt = r_ss;
    if (i_load) begin
      w_hh_nxt = clamp_hh(i_load_hh);
      w_mm_nxt = clamp_ms(i_load_mm, MM_MAX);
      w_ss_nxt = clamp_ms(i_load_ss, SS_MAX);
    end else if (i_tick) begin
      if (r_ss == SS_MAX) begin
        w_ss_nxt = '0;
        if (r_mm == MM_MAX) begin
          w_mm_nxt = '0;
          w_hh_nxt = (r_hh == HH_MAX) ? '0 : r_hh + 5'd1;
        end else begin
          w_mm_nxt = r_mm + 6'd1;
        end
      end else begin
        w_ss_nxt = r_ss + 6'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hh <= '0;
      r_mm <= '0;
      r_ss <= '0;
    end else begin
      r_hh <= w_hh_nxt;
      r_mm <= w_mm_nxt;
      r_ss <= w_ss_nxt;
    end
  end

  assign o_hh = r_hh;
  assign o_mm = r_mm;
  assign o_ss = r_ss;

endmodule

// File: rtl/rtc_timebase_ctrl.sv
// RTC prescaler controller: IDLE holds count at 0, RUN counts and ticks every DIV
// cycles, PAUSE freezes count; divide changes in RUN wait for the period boundary.
module rtc_timebase_ctrl
  import rtc_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 10_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  input  logic [CNT_W-1:0] i_div_value,
  input  logic             i_time_load,
  input  logic [HH_W-1:0]  i_load_hh,
  input  logic [MS_W-1:0]  i_load_mm,
  input  logic [MS_W-1:0]  i_load_ss,
  output logic             o_tick,
  output logic [HH_W-1:0]  o_hh,
  output logic [MS_W-1:0]  o_mm,
  output logic [MS_W-1:0]  o_ss,
  output logic [1:0]       o_state
);

  rtc_state_e       r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_valid;
  logic             r_tick;

  rtc_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_pend_div_nxt;
  logic             w_pend_valid_nxt;
  logic             w_tick_nxt;

  logic             w_counting;
  logic             w_wrap;
  logic             w_div_xfer;
  logic [CNT_W-1:0] w_div_clamped;

  assign w_counting    = (r_state == ST_RUN) && i_run;
  assign w_wrap        = w_counting && (r_count == (r_div - CNT_W'(1)));
  assign w_div_xfer    = i_div_valid && !r_pend_valid;
  assign w_div_clamped = (i_div_value < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : i_div_value;

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_div_nxt        = r_div;
    w_pend_div_nxt   = r_pend_div;
    w_pend_valid_nxt = r_pend_valid;
    w_tick_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_count_nxt = '0;
        if (i_run) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!i_run) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_wrap) begin
          w_count_nxt = '0;
          w_tick_nxt  = 1'b1;
          if (r_pend_valid) begin
            w_div_nxt        = r_pend_div;
            w_pend_valid_nxt = 1'b0;
          end
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      ST_PAUSE: begin
        if (i_run) w_state_nxt = ST_RUN;
        // A ratio left pending when the pause began takes effect now, restarting the period.
        if (r_pend_valid) begin
          w_div_nxt        = r_pend_div;
          w_pend_valid_nxt = 1'b0;
          w_count_nxt      = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_div_xfer) begin
      if (r_state == ST_RUN) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_div_nxt   = w_div_clamped;
      end else begin
        w_div_nxt   = w_div_clamped;
        w_count_nxt = '0;
      end
    end

    // Time load restarts the period; a tick landing on the same edge would be short.
    if (i_time_load) begin
      w_count_nxt = '0;
      w_tick_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count      <= '0;
      r_div        <= CNT_W'(DEFAULT_DIV);
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_div        <= w_div_nxt;
      r_pend_div   <= w_pend_div_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_tick       <= w_tick_nxt;
    end
  end

  rtc_tod_counter u_tod (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_tick    (r_tick),
    .i_load    (i_time_load),
    .i_load_hh (i_load_hh),
    .i_load_mm (i_load_mm),
    .i_load_ss (i_load_ss),
    .o_hh      (o_hh),
    .o_mm      (o_mm),
    .o_ss      (o_ss)
  );

  assign o_tick      = r_tick;
  assign o_div_ready = !r_pend_valid;
  assign o_state     = r_state;

endmodule

// File: tb/tb_rtc_timebase_ctrl.sv
// Self-checking bench for rtc_timebase_ctrl: expected tick cycles are queued when
// stimulus is applied and popped by a monitor whenever o_tick is seen.
module tb_rtc_timebase_ctrl;

  localparam int CNT_W = 32;
  localparam int DIV0  = 10;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             div_valid;
  logic             div_ready;
  logic [CNT_W-1:0] div_value;
  logic             time_load;
  logic [4:0]       load_hh;
  logic [5:0]       load_mm;
  logic [5:0]       load_ss;
  logic             tick;
  logic [4:0]       hh;
  logic [5:0]       mm;
  logic [5:0]       ss;
  logic [1:0]       state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_tick_q[$];

  rtc_timebase_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DIV0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (run),
    .i_div_valid (div_valid),
    .o_div_ready (div_ready),
    .i_div_value (div_value),
    .i_time_load (time_load),
    .i_load_hh   (load_hh),
    .i_load_mm   (load_mm),
    .i_load_ss   (load_ss),
    .o_tick      (tick),
    .o_hh        (hh),
    .o_mm        (mm),
    .o_ss        (ss),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Cycle c is the interval after the c-th rising edge; sampled at its falling edge.
  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_time(input string tag, input int e_hh, input int e_mm, input int e_ss);
    check_val({tag, "_hh"}, hh, e_hh);
    check_val({tag, "_mm"}, mm, e_mm);
    check_val({tag, "_ss"}, ss, e_ss);
  endtask

  always @(negedge clk) begin
    if (rst_n && tick) begin
      if (exp_tick_q.size() == 0) begin
        check_val("tick_unexpected", 1, 0);
      end else begin
        check_val("tick_cycle", cyc, exp_tick_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, p, l, r2;
    rst_n     = 1'b0;
    run       = 1'b0;
    div_valid = 1'b0;
    div_value = '0;
    time_load = 1'b0;
    load_hh   = '0;
    load_mm   = '0;
    load_ss   = '0;

    @(negedge clk);
    check_val("rst_state", state, 0);
    check_val("rst_tick", tick, 0);
    check_val("rst_ready", div_ready, 1);
    check_time("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    goto(cyc + 2);
    check_val("idle_hold", state, 0);

    // Start: first RUN cycle has count 0, tick DIV cycles later.
    run = 1'b1;
    r = cyc + 1;
    exp_tick_q.push_back(r + 10);
    exp_tick_q.push_back(r + 20);
    exp_tick_q.push_back(r + 30);
    goto(r);
    check_val("run_state", state, 1);
    goto(r + 11);
    check_val("ss_after_t1", ss, 1);
    goto(r + 21);
    check_val("ss_after_t2", ss, 2);
    goto(r + 31);
    check_val("ss_after_t3", ss, 3);

    // Divide change at count 3: old period finishes at 10, then period 4.
    goto(r + 33);
    check_val("ready_before_wr", div_ready, 1);
    div_valid = 1'b1;
    div_value = 4;
    t = r + 40;
    exp_tick_q.push_back(t);
    exp_tick_q.push_back(t + 4);
    exp_tick_q.push_back(t + 8);
    goto(r + 34);
    div_valid = 1'b0;
    check_val("ready_pending", div_ready, 0);
    goto(r + 39);
    check_val("ready_pending_end", div_ready, 0);
    goto(r + 40);
    check_val("ready_restored", div_ready, 1);

    // Pause with count frozen at 2; resume finishes the remaining 2 counts.
    goto(t + 10);
    run = 1'b0;
    exp_tick_q.push_back(t + 33);
    exp_tick_q.push_back(t + 37);
    exp_tick_q.push_back(t + 41);
    goto(t + 20);
    check_val("pause_state", state, 2);
    goto(t + 30);
    run = 1'b1;
    goto(t + 31);
    check_val("resume_state", state, 1);

    // Time load and midnight rollover.
    p = t + 41;
    l = p + 1;
    goto(l);
    time_load = 1'b1;
    load_hh = 23;
    load_mm = 59;
    load_ss = 58;
    exp_tick_q.push_back(l + 5);
    exp_tick_q.push_back(l + 9);
    goto(l + 1);
    time_load = 1'b0;
    check_time("load1", 23, 59, 58);
    goto(l + 6);
    check_time("roll_a", 23, 59, 59);
    goto(l + 10);
    check_time("midnight", 0, 0, 0);
    time_load = 1'b1;
    load_hh = 30;
    load_mm = 62;
    load_ss = 63;
    exp_tick_q.push_back(l + 15);
    goto(l + 11);
    time_load = 1'b0;
    check_time("clamp", 23, 59, 59);
    goto(l + 16);
    check_time("clamp_roll", 0, 0, 0);

    // Load on the same cycle as a tick while showing 00:00:05.
    for (int k = 19; k <= 39; k += 4) exp_tick_q.push_back(l + k);
    exp_tick_q.push_back(l + 44);
    goto(l + 39);
    check_val("coinc_tick", tick, 1);
    check_val("coinc_ss", ss, 5);
    time_load = 1'b1;
    load_hh = 12;
    load_mm = 0;
    load_ss = 0;
    goto(l + 40);
    time_load = 1'b0;
    check_time("load_wins", 12, 0, 0);
    goto(l + 45);
    check_time("after_load_tick", 12, 0, 1);

    // Divide 0 written in PAUSE clamps to 2 and restarts the period.
    goto(l + 46);
    run = 1'b0;
    goto(l + 48);
    check_val("pause2_state", state, 2);
    check_val("pause2_ready", div_ready, 1);
    div_valid = 1'b1;
    div_value = 0;
    goto(l + 49);
    div_valid = 1'b0;
    goto(l + 50);
    run = 1'b1;
    exp_tick_q.push_back(l + 53);
    exp_tick_q.push_back(l + 55);
    exp_tick_q.push_back(l + 57);

    // Asynchronous reset in the middle of a tick cycle.
    goto(l + 57);
    check_time("pre_reset", 12, 0, 3);
    #2;
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check_val("arst_state", state, 0);
    check_val("arst_tick", tick, 0);
    check_val("arst_ready", div_ready, 1);
    check_time("arst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    goto(l + 59);
    run = 1'b1;
    r2 = cyc + 1;
    exp_tick_q.push_back(r2 + 10);
    goto(r2 + 12);
    check_val("div_default_ss", ss, 1);

    goto(cyc + 5);
    check_val("sb_empty", exp_tick_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
